// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell walks the operands LSB first,
// then publishes result, carry and signed overflow alongside a one-cycle done pulse.

module FA_design (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Sum,
    output logic Carry
);
    assign Sum   = A ^ B ^ C;
    assign Carry = (A & B) | (C & (A ^ B));
endmodule

module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   areg_q, areg_d;
    logic [WIDTH-1:0]   breg_q, breg_d;
    logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_sum, fa_carry;
    logic [WIDTH-1:0]   sum_next;

    FA_design u_fa (
        .A     (areg_q[0]),
        .B     (breg_q[0]),
        .C     (carry_q),
        .Sum   (fa_sum),
        .Carry (fa_carry)
    );

    // Partial sums live in sum_sr so the visible result only changes at RUN->DONE.
    assign sum_next = {fa_sum, sum_sr_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        sum_sr_d = sum_sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    areg_d  = a;
                    breg_d  = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                sum_sr_d = sum_next[WIDTH-1:1];
                carry_d  = fa_carry;
                areg_d   = areg_q >> 1;
                breg_d   = breg_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = sum_next;
                    cout_d   = fa_carry;
                    ovf_d    = carry_q ^ fa_carry;
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            areg_q   <= '0;
            breg_q   <= '0;
            sum_sr_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            sum_sr_q <= sum_sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: expected results are queued when an operation
// is launched and popped when done is observed.

module tb_serial_addsub_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        ready, busy, done, carry_out, overflow;
    logic [63:0] result;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    serial_addsub_ctrl #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] xa, input logic [63:0] xb, input logic sub);
        exp_t        e;
        logic [64:0] full;
        if (sub) full = {1'b0, xa} - {1'b0, xb};
        else     full = {1'b0, xa} + {1'b0, xb};
        e.r = full[63:0];
        // Subtraction reports carry = no borrow, i.e. inverse of the 65-bit borrow bit.
        e.c = sub ? ~full[64] : full[64];
        if (sub) e.v = (xa[63] != xb[63]) && (e.r[63] != xa[63]);
        else     e.v = (xa[63] == xb[63]) && (e.r[63] != xa[63]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] xa, input logic [63:0] xb, input logic sub);
        start  = 1'b1;
        a      = xa;
        b      = xb;
        op_sub = sub;
        sb.push_back(model(xa, xb, sub));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 1;
        busy_n = busy ? 1 : 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
        checks++; if ({result, carry_out, overflow} !== 66'd0)
            $display("FAIL reset_outputs got %h/%b/%b want 0/0/0", result, carry_out, overflow); else passes++;
        // Reset and start together: reset must win.
        start = 1'b1;
        a = 64'd9; b = 64'd9;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        checks++; if (busy !== 1'b0 || ready !== 1'b1)
            $display("FAIL reset_with_start got busy=%b ready=%b want busy=0 ready=1", busy, ready); else passes++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset_with_start_late got busy=%b want 0", busy); else passes++;
    endtask

    task automatic test_add_wrap();
        int   cyc, bn;
        exp_t e;
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_done(cyc, bn);
        checks++; if (cyc !== 65) $display("FAIL add_wrap_done_cycle got %0d want 65", cyc); else passes++;
        checks++; if (bn !== 64) $display("FAIL add_wrap_busy_cycles got %0d want 64", bn); else passes++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (result !== e.r) $display("FAIL add_wrap_result got %h want %h", result, e.r); else passes++;
        checks++; if (carry_out !== e.c || overflow !== e.v)
            $display("FAIL add_wrap_flags got c=%b v=%b want c=%b v=%b", carry_out, overflow, e.c, e.v); else passes++;
        tick();
        checks++; if (ready !== 1'b1 || done !== 1'b0)
            $display("FAIL add_wrap_cycle66 got ready=%b done=%b want 1/0", ready, done); else passes++;
        checks++; if (result !== e.r) $display("FAIL add_wrap_hold got %h want %h", result, e.r); else passes++;
    endtask

    task automatic test_sub();
        logic [63:0] ta [2] = '{64'd5, 64'd7};
        logic [63:0] tb [2] = '{64'd7, 64'd5};
        for (int i = 0; i < 2; i++) begin
            int   cyc, bn;
            exp_t e;
            launch(ta[i], tb[i], 1'b1);
            wait_done(cyc, bn);
            checks++; if (cyc !== 65) $display("FAIL sub%0d_done_cycle got %0d want 65", i, cyc); else passes++;
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (result !== e.r) $display("FAIL sub%0d_result got %h want %h", i, result, e.r); else passes++;
            checks++; if (carry_out !== e.c || overflow !== e.v)
                $display("FAIL sub%0d_flags got c=%b v=%b want c=%b v=%b", i, carry_out, overflow, e.c, e.v); else passes++;
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [63:0] ta [2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic [63:0] tb [2] = '{64'd1, 64'd1};
        logic        ts [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            int   cyc, bn;
            exp_t e;
            launch(ta[i], tb[i], ts[i]);
            wait_done(cyc, bn);
            checks++; if (cyc !== 65) $display("FAIL ovf%0d_done_cycle got %0d want 65", i, cyc); else passes++;
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (result !== e.r) $display("FAIL ovf%0d_result got %h want %h", i, result, e.r); else passes++;
            checks++; if (carry_out !== e.c || overflow !== e.v)
                $display("FAIL ovf%0d_flags got c=%b v=%b want c=%b v=%b", i, carry_out, overflow, e.c, e.v); else passes++;
            tick();
        end
    endtask

    task automatic test_start_ignored();
        int   cyc, bn, dn, dcyc;
        exp_t e;
        launch(64'd3, 64'd4, 1'b0);
        cyc = 1; bn = busy ? 1 : 0; dn = 0; dcyc = -1;
        while (cyc < 80) begin
            if (cyc == 10) begin
                start = 1'b1; a = 64'd100; b = 64'd100;
            end else begin
                start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op_sub = 1'($urandom);
            end
            tick();
            cyc++;
            if (busy) bn++;
            if (done) begin
                dn++;
                dcyc = cyc;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                checks++; if (result !== e.r) $display("FAIL ignore_result got %h want %h", result, e.r); else passes++;
            end
        end
        start = 1'b0;
        checks++; if (dn !== 1) $display("FAIL ignore_done_count got %0d want 1", dn); else passes++;
        checks++; if (dcyc !== 65) $display("FAIL ignore_done_cycle got %0d want 65", dcyc); else passes++;
        checks++; if (bn !== 64) $display("FAIL ignore_busy_cycles got %0d want 64", bn); else passes++;
    endtask

    task automatic test_reset_mid_run();
        int   cyc, bn, dn;
        exp_t e;
        launch(64'd5, 64'd6, 1'b0);
        cyc = 1;
        while (cyc < 30) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_ctrl got r=%b b=%b d=%b want 1/0/0", ready, busy, done); else passes++;
        checks++; if ({result, carry_out, overflow} !== 66'd0)
            $display("FAIL midrst_outputs got %h/%b/%b want 0/0/0", result, carry_out, overflow); else passes++;
        dn = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) dn++;
        end
        checks++; if (dn !== 0) $display("FAIL midrst_no_done got %0d want 0", dn); else passes++;
        launch(64'd10, 64'd20, 1'b0);
        wait_done(cyc, bn);
        checks++; if (cyc !== 65) $display("FAIL midrst_next_cycle got %0d want 65", cyc); else passes++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (result !== e.r) $display("FAIL midrst_next_result got %h want %h", result, e.r); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int   t, dn, acc, last, bad;
        exp_t e;
        start = 1'b1; a = 64'd1; b = 64'd2; op_sub = 1'b0;
        t = 0; dn = 0; acc = 0; last = -1; bad = 0;
        while (dn < 3 && t < 400) begin
            if (ready) begin
                sb.push_back(model(64'd1, 64'd2, 1'b0));
                acc++;
            end
            tick();
            t++;
            if (ready && (busy || done)) bad++;
            if (done) begin
                dn++;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                checks++; if (result !== e.r) $display("FAIL b2b_result%0d got %h want %h", dn, result, e.r); else passes++;
                if (last >= 0) begin
                    checks++; if (t - last !== 66) $display("FAIL b2b_spacing%0d got %0d want 66", dn, t - last); else passes++;
                end
                last = t;
            end
        end
        start = 1'b0;
        checks++; if (dn !== 3) $display("FAIL b2b_done_count got %0d want 3", dn); else passes++;
        checks++; if (acc !== 3) $display("FAIL b2b_accepts got %0d want 3", acc); else passes++;
        checks++; if (sb.size() !== 0) $display("FAIL b2b_queue_left got %0d want 0", sb.size()); else passes++;
        checks++; if (bad !== 0) $display("FAIL b2b_ready_exclusive got %0d want 0", bad); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_overflow();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer. Time-shares one FA_design full-adder cell across all WIDTH bit positions of a 64-bit ALU operand pair, LSB first.
- Serves as the low-area add/sub path of the 64-bit ALU.
- Accepts a start request, runs WIDTH carry-chained cycles through the single FA slice, then presents a registered result, carry and signed-overflow flag with a one-cycle done pulse.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 2..64.
- CW, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- op_sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  final carry out of bit WIDTH−1. For subtraction, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Synchronous, active-high reset on clk:
  - state=IDLE, bit counter=0, carry register=0, operand shift registers=0.
  - result=0, carry_out=0, overflow=0, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE.
- IDLE, start=1 (accept edge):
  - Load A shift reg ← a.
  - Load B shift reg ← (op_sub ? ~b : b).
  - Carry reg ← op_sub.
  - Counter ← 0; go to RUN.
- IDLE, start=0: hold. Outputs keep the previous result.
- RUN, each cycle:
  - FA inputs: A=areg[0], B=breg[0], C=carry reg.
  - Shift the FA Sum into the result shift register from the MSB end.
  - Carry reg ← FA Carry.
  - Shift areg and breg right by 1.
  - Counter +1.
- RUN, last cycle (counter=WIDTH−1):
  - Also capture carry_out ← FA Carry.
  - overflow ← carry-in to bit WIDTH−1 XOR carry-out of bit WIDTH−1.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- Latency: start accepted at edge 0; WIDTH RUN cycles; done high in cycle WIDTH+1 (cycle 65 for WIDTH=64); ready high again in cycle WIDTH+2.
- result, carry_out and overflow:
  - Updated only at RUN→DONE.
  - Stable from DONE until the end of the next operation's RUN.
  - result must not be read except when done=1 or later in IDLE.
- start while busy or in DONE: ignored, no queueing, no effect on the current operation.
- Inputs a, b, op_sub may change freely after the accept edge; the captured copies are used.
- Wrap-around: arithmetic is modulo 2^WIDTH. Carry beyond bit WIDTH−1 is reported only on carry_out.
- Reset mid-RUN or in DONE: abort at the reset edge.
  - All state, including result, goes to reset values.
  - No done pulse for the aborted operation.
- Reset together with start: reset wins; start is not accepted.
- Exactly one FA_design instance. No other adder logic in the datapath.

Test Plan:
- WIDTH=64, add, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, carry_out=1, overflow=0, done only in cycle 65, ready=1 in cycle 66.
- Sub, a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0. Also a=7, b=5 -> result=2, carry_out=1.
- Add, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, overflow=1, carry_out=0. Sub, a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Start a=3,b=4 (add); at cycle 10 pulse start with a=100,b=100 and change the a/b inputs -> result=7 at done, one done pulse only, busy=1 cycles 1–64.
- Assert rst in cycle 30 of RUN -> next cycle all outputs at reset values, ready=1, no done. Then a new add 10+20 -> result=30 in cycle 65 after its start.
- Back-to-back: keep start=1 continuously with a=1,b=2 -> operations accepted every 66 cycles, each done pulse with result=3, no start accepted during RUN or DONE.
